conv_mac_acc: RTL and testbench

- Convolution accumulator directly downstream of the picture/weight streaming stage.
- Each valid beat carries one filter tap: channel_paralell_num pixel samples plus one weight for each of conv_num filters.
- Over weight_num beats it multiply-accumulates every (lane, filter) pair, then emits one rescaled, saturated, optionally ReLU'd result per pair.
- Feeds the pooling/next conv stage.

---
 rtl/cnn_fixed_pkg.sv | 20 ++
 rtl/conv_mac_acc_mac_lane.sv | 54 +++++
 rtl/conv_mac_acc.sv | 89 ++++++++
 tb/tb_conv_mac_acc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_fixed_pkg.sv
// Shared signed fixed-point definitions for the CNN datapath stages (conv, pooling).
package cnn_fixed_pkg;

  localparam int BITS      = 16;
  localparam int FRAC_BITS = 8;

  localparam logic signed [BITS-1:0] SAT_MAX = {1'b0, {(BITS-1){1'b1}}};
  localparam logic signed [BITS-1:0] SAT_MIN = {1'b1, {(BITS-1){1'b0}}};

  // Full product width plus headroom for 2^cnt_w - 1 accumulated taps.
  function automatic int acc_width(input int b, input int cnt_w);
    return 2 * b + cnt_w;
  endfunction

  // LSB of element (f, l) in a flat bus of lanes-per-filter elements of b bits.
  function automatic int slice_lsb(input int f, input int l, input int lanes, input int b);
    return (f * lanes + l) * b;
  endfunction

endpackage

// File: rtl/conv_mac_acc_mac_lane.sv
// One (lane, filter) multiply-accumulate with rescale, saturation and optional ReLU.
// The result is combinational from the running sum including the current product.
module mac_lane
  import cnn_fixed_pkg::*;
#(
  parameter int bits         = BITS,
  parameter int frac_bits    = FRAC_BITS,
  parameter int weight_num_2 = 5,
  parameter int acc_bits     = acc_width(bits, weight_num_2),
  parameter bit relu_en      = 1'b1
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   first,
  input  logic signed [bits-1:0] pix,
  input  logic signed [bits-1:0] wgt,
  output logic signed [bits-1:0] result,
  output logic                   sat
);

  localparam logic signed [acc_bits-1:0] HI = {{(acc_bits-bits+1){1'b0}}, {(bits-1){1'b1}}};
  localparam logic signed [acc_bits-1:0] LO = {{(acc_bits-bits+1){1'b1}}, {(bits-1){1'b0}}};

  logic signed [2*bits-1:0]   prod;
  logic signed [acc_bits-1:0] prod_ext;
  logic signed [acc_bits-1:0] acc_q;
  logic signed [acc_bits-1:0] acc_next;
  logic signed [acc_bits-1:0] scaled;
  logic                       sat_hi;
  logic                       sat_lo;

  assign prod     = (2*bits)'(pix) * (2*bits)'(wgt);
  assign prod_ext = {{(acc_bits-2*bits){prod[2*bits-1]}}, prod};
  // First tap overwrites so consecutive windows need no bubble.
  assign acc_next = first ? prod_ext : acc_q + prod_ext;
  assign scaled   = acc_next >>> frac_bits;
  assign sat_hi   = scaled > HI;
  assign sat_lo   = scaled < LO;
  assign sat      = sat_hi | sat_lo;

  always_comb begin
    if (sat_hi)      result = HI[bits-1:0];
    else if (sat_lo) result = LO[bits-1:0];
    else             result = scaled[bits-1:0];
    if (relu_en && result[bits-1]) result = '0;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)  acc_q <= '0;
    else if (en) acc_q <= acc_next;
  end

endmodule

// File: rtl/conv_mac_acc.sv
// Convolution MAC array: accumulates weight_num taps per (lane, filter), emits rescaled results.
// Result pulse one cycle after the last accepted tap; no backpressure, clear restarts the window.
module conv_mac_acc
  import cnn_fixed_pkg::*;
#(
  parameter int bits                 = BITS,
  parameter int frac_bits            = FRAC_BITS,
  parameter int channel_paralell_num = 16,
  parameter int conv_num             = 4,
  parameter int weight_num           = 25,
  parameter int weight_num_2         = 5,
  parameter int acc_bits             = acc_width(bits, weight_num_2),
  parameter bit relu_en              = 1'b1
) (
  input  logic                                         clk_in,
  input  logic                                         rst_n,
  input  logic                                         clear,
  input  logic                                         in_valid,
  input  logic [channel_paralell_num*bits-1:0]          map,
  input  logic [conv_num*bits-1:0]                      weight,
  output logic                                         out_valid,
  output logic [conv_num*channel_paralell_num*bits-1:0] out_data,
  output logic [15:0]                                  window_cnt,
  output logic                                         sat_flag
);

  localparam int                      LANES    = conv_num * channel_paralell_num;
  localparam logic [weight_num_2-1:0] LAST_TAP = weight_num_2'(weight_num - 1);

  logic [weight_num_2-1:0] tap_cnt;
  logic                    accept;
  logic                    first_tap;
  logic                    last_beat;
  logic [LANES*bits-1:0]   result_all;
  logic [LANES-1:0]        sat_all;

  assign accept    = in_valid & ~clear;
  assign first_tap = (tap_cnt == '0);
  assign last_beat = accept && (tap_cnt == LAST_TAP);

  for (genvar f = 0; f < conv_num; f++) begin : g_filter
    for (genvar l = 0; l < channel_paralell_num; l++) begin : g_lane
      localparam int LSB_O = slice_lsb(f, l, channel_paralell_num, bits);
      localparam int LSB_M = slice_lsb(0, l, channel_paralell_num, bits);
      localparam int LSB_W = slice_lsb(0, f, 1, bits);

      mac_lane #(
        .bits         (bits),
        .frac_bits    (frac_bits),
        .weight_num_2 (weight_num_2),
        .acc_bits     (acc_bits),
        .relu_en      (relu_en)
      ) u_lane (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (accept),
        .first  (first_tap),
        .pix    (map[LSB_M +: bits]),
        .wgt    (weight[LSB_W +: bits]),
        .result (result_all[LSB_O +: bits]),
        .sat    (sat_all[f*channel_paralell_num + l])
      );
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      window_cnt <= '0;
      sat_flag   <= 1'b0;
    end else if (clear) begin
      tap_cnt    <= '0;
      out_valid  <= 1'b0;
      window_cnt <= '0;
      sat_flag   <= 1'b0;
    end else begin
      out_valid <= last_beat;
      if (accept) tap_cnt <= last_beat ? '0 : tap_cnt + 1'b1;
      if (last_beat) begin
        out_data   <= result_all;
        window_cnt <= window_cnt + 16'd1;
        if (|sat_all) sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_acc.sv
// Self-checking bench: uniform-value vector table, corner sequences, and randomized windows
// checked against a window-sum reference model.
module tb_conv_mac_acc;

  localparam int B  = 16;
  localparam int CH = 16;
  localparam int CN = 4;
  localparam int WN = 25;
  localparam int N  = CH * CN;
  localparam int OW = N * B;

  logic            clk_in = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            in_valid = 1'b0;
  logic [CH*B-1:0] map = '0;
  logic [CN*B-1:0] weight = '0;

  logic          ov1, ov0, sf1, sf0;
  logic [OW-1:0] od1, od0;
  logic [15:0]   wc1, wc0;

  conv_mac_acc #(.relu_en(1'b1)) dut_relu (
    .clk_in(clk_in), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .map(map), .weight(weight), .out_valid(ov1), .out_data(od1),
    .window_cnt(wc1), .sat_flag(sf1));

  conv_mac_acc #(.relu_en(1'b0)) dut_lin (
    .clk_in(clk_in), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .map(map), .weight(weight), .out_valid(ov0), .out_data(od0),
    .window_cnt(wc0), .sat_flag(sf0));

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: plain per-window sums of products.
  longint        sums[CN][CH];
  int            taps = 0;
  int            m_wcnt = 0;
  bit            m_sat = 0;
  int            exp_cyc[$];
  logic [OW-1:0] exp_d1[$];
  logic [OW-1:0] exp_d0[$];
  int            got_c1[$];
  int            got_c0[$];
  logic [OW-1:0] got_d1[$];
  logic [OW-1:0] got_d0[$];

  typedef struct {
    logic [15:0] m;
    logic [15:0] w;
    logic [15:0] r_relu;
    logic [15:0] r_lin;
    bit          sat;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [B-1:0] quant(input longint s, input bit relu);
    longint r;
    r = s >>> 8;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return B'(r);
  endfunction

  function automatic bit saturates(input longint s);
    longint r;
    r = s >>> 8;
    return (r > 32767) || (r < -32768);
  endfunction

  function automatic logic [OW-1:0] rep_out(input logic [15:0] v);
    logic [OW-1:0] o;
    for (int i = 0; i < N; i++) o[i*B +: B] = v;
    return o;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < N; i++) begin
        if (act[i*B +: B] !== exp[i*B +: B]) begin
          $display("FAIL %s: result %0d got %h expected %h", name, i, act[i*B +: B], exp[i*B +: B]);
          break;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    if (ov1) begin got_c1.push_back(cyc); got_d1.push_back(od1); end
    if (ov0) begin got_c0.push_back(cyc); got_d0.push_back(od0); end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic beat(input logic [CH*B-1:0] m, input logic [CN*B-1:0] w);
    logic [OW-1:0] e1, e0;
    longint        p;
    map = m; weight = w; in_valid = 1'b1;
    for (int f = 0; f < CN; f++)
      for (int l = 0; l < CH; l++) begin
        p = longint'($signed(m[l*B +: B])) * longint'($signed(w[f*B +: B]));
        sums[f][l] = (taps == 0) ? p : sums[f][l] + p;
      end
    taps++;
    if (taps == WN) begin
      for (int f = 0; f < CN; f++)
        for (int l = 0; l < CH; l++) begin
          e1[(f*CH+l)*B +: B] = quant(sums[f][l], 1'b1);
          e0[(f*CH+l)*B +: B] = quant(sums[f][l], 1'b0);
          if (saturates(sums[f][l])) m_sat = 1'b1;
        end
      exp_cyc.push_back(cyc + 1);
      exp_d1.push_back(e1);
      exp_d0.push_back(e0);
      m_wcnt = (m_wcnt + 1) & 16'hFFFF;
      taps = 0;
    end
    tick();
  endtask

  task automatic ubeats(input int n, input logic [15:0] mv, input logic [15:0] wv);
    repeat (n) beat({CH{mv}}, {CN{wv}});
  endtask

  // in_valid stays high during clear so a wrongly accepted beat would misalign the window.
  task automatic do_clear();
    clear = 1'b1; in_valid = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    taps = 0; m_wcnt = 0; m_sat = 1'b0;
  endtask

  task automatic verify(input string tag);
    chk({tag, " pulse count"}, got_c1.size(), exp_cyc.size());
    chk({tag, " pulse count lin"}, got_c0.size(), exp_cyc.size());
    for (int i = 0; i < exp_cyc.size(); i++) begin
      if (i < got_c1.size()) begin
        chk({tag, " pulse cycle"}, got_c1[i], exp_cyc[i]);
        chk_data({tag, " data relu"}, got_d1[i], exp_d1[i]);
      end
      if (i < got_c0.size()) begin
        chk({tag, " pulse cycle lin"}, got_c0[i], exp_cyc[i]);
        chk_data({tag, " data lin"}, got_d0[i], exp_d0[i]);
      end
    end
    chk({tag, " window_cnt"}, wc1, m_wcnt);
    chk({tag, " window_cnt lin"}, wc0, m_wcnt);
    chk({tag, " sat_flag"}, sf1, m_sat);
    chk({tag, " sat_flag lin"}, sf0, m_sat);
    exp_cyc.delete(); exp_d1.delete(); exp_d0.delete();
    got_c1.delete(); got_c0.delete(); got_d1.delete(); got_d0.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int start;
    logic [CH*B-1:0] rm;
    logic [CN*B-1:0] rw;
    bit big;

    tbl[0] = '{16'd256,    16'd256,    16'd6400,   16'd6400,   1'b0};
    tbl[1] = '{16'd256,    16'hFF00,   16'd0,      16'hE700,   1'b0};
    tbl[2] = '{16'h7FFF,   16'h7FFF,   16'h7FFF,   16'h7FFF,   1'b1};
    tbl[3] = '{16'h8000,   16'h7FFF,   16'd0,      16'h8000,   1'b1};
    tbl[4] = '{16'd512,    16'd512,    16'd25600,  16'd25600,  1'b0};
    tbl[5] = '{16'd1,      16'hFFFF,   16'd0,      16'hFFFF,   1'b0};
    tbl[6] = '{16'd100,    16'd3,      16'd29,     16'd29,     1'b0};

    #12;
    chk("reset out_valid", ov1, 0);
    chk_data("reset out_data", od1, '0);
    chk_data("reset out_data lin", od0, '0);
    chk("reset window_cnt", wc1, 0);
    chk("reset sat_flag", sf1, 0);
    rst_n = 1'b1;
    idle(2);

    foreach (tbl[i]) begin
      do_clear();
      ubeats(WN, tbl[i].m, tbl[i].w);
      idle(2);
      verify($sformatf("tbl%0d", i));
      chk_data($sformatf("tbl%0d const relu", i), od1, rep_out(tbl[i].r_relu));
      chk_data($sformatf("tbl%0d const lin", i), od0, rep_out(tbl[i].r_lin));
      chk($sformatf("tbl%0d sat", i), sf1, tbl[i].sat);
      chk($sformatf("tbl%0d wcnt", i), wc1, 1);
    end

    // Sticky saturation survives a clean window, only clear drops it.
    do_clear();
    ubeats(WN, 16'h7FFF, 16'h7FFF);
    ubeats(WN, 16'd256, 16'd256);
    idle(2);
    verify("sticky");
    chk("sticky sat after clean window", sf1, 1);
    do_clear();
    chk("clear sat_flag", sf1, 0);
    chk("clear window_cnt", wc1, 0);
    chk("clear out_valid", ov1, 0);

    // Stall of 3 cycles after beat 10.
    do_clear();
    start = cyc;
    ubeats(10, 16'd256, 16'd256);
    idle(3);
    ubeats(WN - 10, 16'd256, 16'd256);
    idle(2);
    chk("stall latency", (got_c1.size() > 0) ? got_c1[0] - start : -1, WN + 3);
    verify("stall");

    // Back-to-back windows.
    do_clear();
    ubeats(WN, 16'd256, 16'd256);
    ubeats(WN, 16'd256, 16'd512);
    idle(2);
    chk("b2b spacing", (got_c1.size() > 1) ? got_c1[1] - got_c1[0] : -1, WN);
    chk("b2b first", (got_d1.size() > 0) ? got_d1[0][15:0] : -1, 6400);
    chk("b2b second", (got_d1.size() > 1) ? got_d1[1][15:0] : -1, 12800);
    verify("b2b");
    chk("b2b window_cnt", wc1, 2);

    // Clear mid-window discards the partial sum.
    do_clear();
    ubeats(10, 16'd256, 16'd512);
    do_clear();
    ubeats(WN, 16'd256, 16'd256);
    idle(2);
    verify("restart");
    chk("restart window_cnt", wc1, 1);
    chk_data("restart data", od1, rep_out(16'd6400));

    // Async reset mid-window after a saturating window.
    do_clear();
    ubeats(WN, 16'h7FFF, 16'h7FFF);
    idle(1);
    verify("pre-reset");
    ubeats(10, 16'd256, 16'd256);
    #2 rst_n = 1'b0;
    #1;
    chk("areset out_valid", ov1, 0);
    chk_data("areset out_data", od1, '0);
    chk("areset window_cnt", wc1, 0);
    chk("areset sat_flag", sf1, 0);
    in_valid = 1'b0;
    taps = 0; m_wcnt = 0; m_sat = 1'b0;
    #1 rst_n = 1'b1;
    ubeats(WN, 16'd256, 16'd256);
    idle(2);
    verify("post-reset");
    chk_data("post-reset data", od1, rep_out(16'd6400));

    // Randomized windows with random gaps.
    do_clear();
    for (int w = 0; w < 8; w++) begin
      big = 1'($urandom_range(0, 1));
      for (int t = 0; t < WN; t++) begin
        for (int l = 0; l < CH; l++)
          rm[l*B +: B] = big ? B'($urandom) : B'($urandom_range(0, 600) - 300);
        for (int f = 0; f < CN; f++)
          rw[f*B +: B] = big ? B'($urandom) : B'($urandom_range(0, 600) - 300);
        beat(rm, rw);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(2);
    verify("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
